// File: rtl/qdi_pkg.sv
// Shared types and helpers for the binary-to-1-of-4 QDI transmitter.
package qdi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RTZ
  } qdiState_e;

  localparam logic [3:0] QDI_NEUTRAL_1OF4 = 4'b0000;

  function automatic logic [3:0] onehot_1of4(input logic [1:0] val);
    onehot_1of4 = 4'b0001 << val;
  endfunction

endpackage

// File: rtl/qdi_sync_fifo.sv
// Small synchronous FIFO. The empty flag lags the occupancy count by one cycle,
// so a freshly pushed entry becomes poppable two edges after the push.
module qdi_sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pushValid,
  output logic             pushReady,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             empty,
  output logic             occupied
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic [AW:0]      cnt;
  logic             headVld;
  logic             doPush, doPop;

  assign pushReady = (cnt != (AW+1)'(DEPTH));
  assign doPush    = pushValid && pushReady;
  assign doPop     = pop && headVld;
  assign popData   = mem[rdPtr];
  assign empty     = !headVld;
  assign occupied  = (cnt != '0);

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      cnt     <= '0;
      headVld <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // Cleared on a pop so the next head gets a full cycle to settle.
      headVld <= (cnt != '0) && !doPop;
    end
  end

endmodule

// File: rtl/bin2qdi_sync_1of4.sv
// Clocked valid/ready 2-bit stream to 1-of-4 four-phase QDI channel bridge.
// Txe is synchronized; Tx only moves neutral->one-hot or one-hot->neutral.
module bin2qdi_sync_1of4
  import qdi_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [1:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [3:0]         Tx,
  input  logic               Txe,
  output logic [COUNT_W-1:0] tok_count,
  output logic               busy
);
  logic [SYNC_STAGES-1:0] txeSync;
  logic                   txeS;
  qdiState_e              state, stateNext;
  logic [3:0]             txNext;
  logic [COUNT_W-1:0]     cntNext;
  logic                   pop;
  logic [1:0]             head;
  logic                   fifoEmpty, fifoOcc;

  qdi_sync_fifo #(.WIDTH(2), .DEPTH(DEPTH)) uFifo (
    .clk      (CLK),
    .rst      (RESET),
    .pushValid(in_valid),
    .pushReady(in_ready),
    .pushData (in_data),
    .pop      (pop),
    .popData  (head),
    .empty    (fifoEmpty),
    .occupied (fifoOcc)
  );

  always_ff @(posedge CLK) begin
    if (RESET) txeSync <= '0;
    else       txeSync <= {txeSync[SYNC_STAGES-2:0], Txe};
  end

  assign txeS = txeSync[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      Tx        <= QDI_NEUTRAL_1OF4;
      tok_count <= '0;
    end else begin
      state     <= stateNext;
      Tx        <= txNext;
      tok_count <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    txNext    = Tx;
    cntNext   = tok_count;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        txNext = QDI_NEUTRAL_1OF4;
        if (txeS && !fifoEmpty) begin
          txNext    = onehot_1of4(head);
          pop       = 1'b1;
          stateNext = DATA;
        end
      end
      DATA: begin
        if (!txeS) begin
          txNext    = QDI_NEUTRAL_1OF4;
          cntNext   = tok_count + COUNT_W'(1);
          stateNext = RTZ;
        end
      end
      RTZ: begin
        txNext = QDI_NEUTRAL_1OF4;
        if (txeS) stateNext = IDLE;
      end
      default: begin
        txNext    = QDI_NEUTRAL_1OF4;
        stateNext = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE) || fifoOcc;

endmodule
